// File: rtl/sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// State encoding and the counter-width helper live here so the top and any
// checker bound to it agree on one definition.
package sub_pkg;

    // Control states: waiting for operands, rippling digits, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a counter that indexes ndig digits; never narrower than one bit
    // so a single-digit configuration still has a legal register.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/sub_digit.sv
// One DIGIT-bit slice of the subtractor: a plain ripple chain of
// full-subtractor cells. Borrow enters at bit 0 and leaves from the MSB cell.
module sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    // br[i] is the borrow into cell i; br[DIGIT] is the borrow out of the slice.
    logic [DIGIT:0] br;

    assign br[0] = bi;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        // Full subtractor: difference is the three-way XOR; borrow when the
        // subtrahend bit (plus incoming borrow) exceeds the minuend bit.
        assign d[i]    = x[i] ^ y[i] ^ br[i];
        assign br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
    end

    assign bo = br[DIGIT];

endmodule

// File: rtl/digit_serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
// clock, LSB digit first, with the inter-digit borrow held in a register.
// Operands arrive and results leave over valid/ready handshakes.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only in IDLE; out_valid is
// high only in DONE, and diff/bout do not change while out_valid waits.
//
// Optional build macro DIGIT_SERIAL_SUB_OVF_EN adds an ovf output carrying the
// signed two's-complement overflow of the subtraction, valid with out_valid.
module digit_serial_sub
    import sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef DIGIT_SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(NDIG);

    // Refuse to build a configuration whose digits do not tile the operand.
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("digit_serial_sub: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
`ifdef DIGIT_SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    logic [DIGIT-1:0]   dig_res;
    logic               dig_bo;
    logic               accept;
    logic               last_dig;

    // The low digit of each shift register is always the one being worked on.
    sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .x  (a_q[DIGIT-1:0]),
        .y  (b_q[DIGIT-1:0]),
        .bi (borrow_q),
        .d  (dig_res),
        .bo (dig_bo)
    );

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_dig = (cnt_q == CNT_W'(NDIG - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, leave RUN after the last digit, release on
    // the output handshake. No re-accept in the same cycle as the release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_dig)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next values: load on accept, shift one digit per RUN cycle,
    // otherwise hold so the result stays put through DONE and after it.
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef DIGIT_SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        if (accept) begin
            a_d      = a;
            b_d      = b;
            borrow_d = bin;
            cnt_d    = '0;
`ifdef DIGIT_SERIAL_SUB_OVF_EN
            a_msb_d  = a[WIDTH-1];
            b_msb_d  = b[WIDTH-1];
`endif
        end else if (state_q == RUN) begin
            borrow_d = dig_bo;
            a_d      = a_q >> DIGIT;
            b_d      = b_q >> DIGIT;
            // New digit enters at the top; after NDIG shifts digit 0 sits at the bottom.
            diff_d   = (diff_q >> DIGIT) | (WIDTH'(dig_res) << (WIDTH - DIGIT));
            cnt_d    = last_dig ? '0 : cnt_q + 1'b1;
            if (last_dig) begin
                bout_d = dig_bo;
`ifdef DIGIT_SERIAL_SUB_OVF_EN
                // The last digit's MSB is the result's sign bit.
                ovf_d  = (a_msb_q != b_msb_q) && (dig_res[DIGIT-1] != a_msb_q);
`endif
            end
        end
    end

    // Datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef DIGIT_SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef DIGIT_SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
`ifdef DIGIT_SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_sub.sv
// Bench for digit_serial_sub: directed scenarios with literal expectations
// plus randomized transactions with random output backpressure, all checked
// every cycle against an arithmetic model of the block.
module tb_digit_serial_sub;

    localparam int WIDTH    = 16;
    parameter  int TB_DIGIT = 4;
    localparam int NDIG     = WIDTH / TB_DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef DIGIT_SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    digit_serial_sub #(
        .WIDTH (WIDTH),
        .DIGIT (TB_DIGIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef DIGIT_SERIAL_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // {borrow, diff} from plain unsigned arithmetic.
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic bi);
        return {1'b0, x} - {1'b0, y} - (WIDTH+1)'(bi);
    endfunction

    function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic bi);
        logic [WIDTH:0] r;
        r = ref_sub(x, y, bi);
        return (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Model: idle flag, cycles left until the result is due, and the result.
    logic             m_idle;
    int               m_wait;
    logic [WIDTH-1:0] m_diff;
    logic             m_bout;
    logic             m_ovf;
    logic             exp_ov;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_wait <= 0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                {m_bout, m_diff} <= ref_sub(a, b, bin);
                m_ovf  <= ref_ovf(a, b, bin);
                m_wait <= NDIG;
                m_idle <= 1'b0;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
        end else if (out_ready) begin
            m_idle <= 1'b1;
        end
    end

    assign exp_ov = !m_idle && (m_wait == 0);

    // Compare process: every cycle out of reset, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", 32'(in_ready), 32'(m_idle));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            if (m_idle || exp_ov) begin
                check("diff", 32'(diff), 32'(m_diff));
                check("bout", 32'(bout), 32'(m_bout));
`ifdef DIGIT_SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(m_ovf));
`endif
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present operands and hold them until accepted; returns #1 after the accept edge.
    task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xbin);
        bit got;
        got      = 1'b0;
        a        = xa;
        b        = xb;
        bin      = xbin;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout in_ready never rose at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid after the accept edge; reports edges taken.
    task automatic wait_result(output int lat);
        lat = 0;
        for (int i = 1; i <= NDIG + 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            errors++;
            $display("FAIL result_timeout out_valid never rose at %0t", $time);
        end
    endtask

    // Full directed transaction with out_ready high; checks literal results.
    task automatic run_txn(input string name, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                           input logic xbin, input logic [WIDTH-1:0] e_diff, input logic e_bout,
                           input logic e_ovf);
        int lat;
        out_ready = 1'b1;
        send(xa, xb, xbin);
        wait_result(lat);
        check({name, "_latency"}, 32'(lat), 32'(NDIG));
        check({name, "_diff"}, 32'(diff), 32'(e_diff));
        check({name, "_bout"}, 32'(bout), 32'(e_bout));
`ifdef DIGIT_SERIAL_SUB_OVF_EN
        check({name, "_ovf"}, 32'(ovf), 32'(e_ovf));
`else
        if (e_ovf) begin end
`endif
        // Handshake happens on the next edge; in_ready must be back after it.
        @(posedge clk);
        #1;
        check({name, "_ready_after_hs"}, 32'(in_ready), 32'd1);
        check({name, "_valid_after_hs"}, 32'(out_valid), 32'd0);
    endtask

    function automatic logic [WIDTH-1:0] rand_operand();
        logic [WIDTH-1:0] corners [4];
        corners[0] = '0;
        corners[1] = '1;
        corners[2] = 16'h8000;
        corners[3] = 16'h7FFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return WIDTH'($urandom);
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    bit rand_done;
    int lat;

    initial begin
        // Reset held for 3 cycles, released away from the edge.
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'h0000);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic subtraction and borrow-ripple cases.
        run_txn("t2", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        run_txn("t3a", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_txn("t3b", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_txn("t3c", 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_txn("ovf1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_txn("ovf2", 16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Backpressure: result held, new operands ignored until release.
        out_ready = 1'b0;
        send(16'h9ABC, 16'h1234, 1'b1);
        wait_result(lat);
        a        = 16'h0100;
        b        = 16'h0001;
        bin      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_diff", 32'(diff), 32'h8887);
            check("bp_bout", 32'(bout), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_after_hs", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result(lat);
        check("bp_next_latency", 32'(lat), 32'(NDIG));
        check("bp_next_diff", 32'(diff), 32'h00FF);
        check("bp_next_bout", 32'(bout), 32'd0);
        @(posedge clk);
        #1;

        // Reset in the second RUN cycle discards the transaction.
        send(16'hFFFF, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'h0000);
        check("midrst_bout", 32'(bout), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn("after_rst", 16'hFFFF, 16'h1111, 1'b0, 16'hEEEE, 1'b0, 1'b0);

        // Randomized transactions with random output backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    send(rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        repeat (NDIG + 4) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
